// File: rtl/gravsim_fpu_pkg.sv
// Shared FPU types and timing constants for the gravity simulator datapath.
package gravsim_fpu_pkg;

  typedef logic [31:0] float32_t;

  localparam int FPU_LATENCY = 4;
  localparam int FIFO_DEPTH  = 4;

  // Width able to hold any count from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_chk.sv
// Checker for the issue controller: the result FIFO never overflows and
// buffered plus in-flight results never exceed the FIFO capacity.
module fpu_issue_ctrl_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          iCLK,
  input logic          iRESET_N,
  input logic          i_push,
  input logic          i_full,
  input logic [CW-1:0] i_inflight,
  input logic [CW-1:0] i_count
);

  a_no_overflow: assert property (@(posedge iCLK) disable iff (!iRESET_N)
    !(i_push && i_full));

  a_credit_bound: assert property (@(posedge iCLK) disable iff (!iRESET_N)
    (int'(i_inflight) + int'(i_count)) <= DEPTH);

endmodule

// File: rtl/fpu_result_fifo.sv
// Result buffer for the FPU issue controller: DEPTH x 32-bit FIFO with
// power-of-two pointer wrap and an occupancy count.
module fpu_result_fifo
  import gravsim_fpu_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          iCLK,
  input  logic          iRESET_N,
  input  logic          i_push,
  input  float32_t      i_data,
  input  logic          i_pop,
  output float32_t      o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);

  float32_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy count.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Credit-based issue controller for a fixed-latency, never-stalled FPU:
// one operand per cycle while a result slot is guaranteed, results buffered in order.
module fpu_issue_ctrl
  import gravsim_fpu_pkg::*;
#(
  parameter int LATENCY = FPU_LATENCY,
  parameter int DEPTH   = FIFO_DEPTH
) (
  input  logic     iCLK,
  input  logic     iRESET_N,
  input  logic     in_valid,
  output logic     in_ready,
  input  float32_t in_data,
  output float32_t fpu_in,
  input  float32_t fpu_out,
  output logic     out_valid,
  input  logic     out_ready,
  output float32_t out_data,
  output logic     busy
);

  localparam int CW = cnt_w(DEPTH);

  logic [LATENCY:0] r_pipe;
  logic [CW-1:0]    r_inflight;
  float32_t         r_fpu_in;
  logic [CW-1:0]    w_fifo_count;
  logic [CW-1:0]    w_credits;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  // A slot is reserved at accept time, so the FIFO always has room when a result lands.
  assign w_credits = CW'(DEPTH) - r_inflight - w_fifo_count;
  assign in_ready  = (w_credits != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_pipe[LATENCY];
  assign w_pop     = out_valid && out_ready;
  assign out_valid = (w_fifo_count != '0);
  assign busy      = (r_inflight != '0) || (w_fifo_count != '0);
  assign fpu_in    = r_fpu_in;

  // Operand register, issue-pipe valid tracking and in-flight count.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_pipe     <= '0;
      r_inflight <= '0;
      r_fpu_in   <= '0;
    end else begin
      r_pipe <= {r_pipe[LATENCY-1:0], w_accept};
      if (w_accept) r_fpu_in <= in_data;
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  fpu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .i_push   (w_push),
    .i_data   (fpu_out),
    .i_pop    (w_pop),
    .o_data   (out_data),
    .o_count  (w_fifo_count),
    .o_full   (w_full)
  );

  fpu_issue_ctrl_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .iCLK       (iCLK),
    .iRESET_N   (iRESET_N),
    .i_push     (w_push),
    .i_full     (w_full),
    .i_inflight (r_inflight),
    .i_count    (w_fifo_count)
  );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: reciprocal FPU model, accept-time scoreboard,
// latency/throughput, backpressure, wrap and mid-flight reset scenarios.
module tb_fpu_issue_ctrl;
  import gravsim_fpu_pkg::*;

  localparam int LAT = 4;
  localparam int DEP = 4;

  logic     iCLK = 1'b0;
  logic     iRESET_N = 1'b0;
  logic     in_valid = 1'b0;
  logic     in_ready;
  float32_t in_data = 32'd0;
  float32_t fpu_in;
  float32_t fpu_out;
  logic     out_valid;
  logic     out_ready = 1'b0;
  float32_t out_data;
  logic     busy;

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  int n_out = 0;
  int cyc = 0;
  logic [31:0] sb_q[$];
  logic [31:0] stim_q[$];
  int out_cyc[$];
  float32_t fpu_pipe [LAT];

  fpu_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .iCLK(iCLK), .iRESET_N(iRESET_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fpu_in(fpu_in), .fpu_out(fpu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [31:0] recip_f32(input logic [31:0] x);
    logic [63:0] d;
    logic [63:0] q;
    logic [33:0] t;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    q = $realtobits(1.0 / $bitstoreal(d));
    t = {q[62:52], q[51:29]} + 34'(q[28]);
    return {q[63], 8'(int'(t[33:23]) - 1023 + 127), t[22:0]};
  endfunction

  function automatic logic [31:0] sb_pop();
    if (sb_q.size() != 0) return sb_q.pop_front();
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural FPU: reciprocal with exactly LAT cycles from fpu_in update.
  always @(posedge iCLK) begin
    fpu_pipe[0] <= recip_f32(fpu_in);
    for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign fpu_out = fpu_pipe[LAT-1];

  always @(posedge iCLK) cyc <= cyc + 1;

  // Handshakes sampled mid-cycle; each one completes on the next rising edge.
  always @(negedge iCLK) begin
    if (iRESET_N) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(recip_f32(in_data));
        n_acc <= n_acc + 1;
      end
      if (out_valid && out_ready) begin
        check_eq("sb_out", out_data, sb_pop());
        n_out <= n_out + 1;
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive_all(input int budget);
    logic acc;
    int t;
    t = 0;
    while (stim_q.size() != 0 && t < budget) begin
      in_valid = 1'b1;
      in_data  = stim_q[0];
      @(negedge iCLK);
      acc = in_ready;
      @(posedge iCLK); #1;
      if (acc) void'(stim_q.pop_front());
      t++;
    end
    in_valid = 1'b0;
    check_eq("drv_done", 32'(stim_q.size()), 32'd0);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (sb_q.size() != 0 || busy); i++) begin
      @(posedge iCLK); #1;
    end
    check_eq({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] b2b [8];
    int edges;
    int base;
    int ovs;
    logic done;
    b2b = '{32'h40000000, 32'h40800000, 32'h3F000000, 32'h41133333,
            32'h40400000, 32'h41200000, 32'hBF800000, 32'h3E800000};

    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    check_eq("rst_fpu_in", fpu_in, 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    iRESET_N = 1'b1;
    @(posedge iCLK); #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Single op: 2.0 -> 0.5, latency LAT+1 edges
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h40000000;
    @(posedge iCLK); #1;
    in_valid = 1'b0;
    check_eq("single_fpu_in", fpu_in, 32'h40000000);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge iCLK); #1;
      edges++;
    end
    check_eq("single_latency", 32'(edges), 32'(LAT + 1));
    check_eq("single_result", out_data, 32'h3F000000);
    @(posedge iCLK); #1;
    check_eq("single_busy_after_pop", 32'(busy), 32'd0);
    check_eq("single_fpu_in_hold", fpu_in, 32'h40000000);

    // Back-to-back: 8 operands offered every cycle
    out_cyc.delete();
    base = n_out;
    for (int i = 0; i < 8; i++) stim_q.push_back(b2b[i]);
    drive_all(100);
    drain("b2b", 60);
    check_eq("b2b_count", 32'(n_out - base), 32'd8);
    for (int i = 1; i < DEP; i++)
      check_eq("b2b_no_bubble", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);

    // Backpressure: consumer stalled, 6 offered
    out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++) stim_q.push_back(32'h3F800000 + 32'(i) * 32'h00100000);
    fork
      drive_all(100);
      begin
        repeat (15) @(posedge iCLK);
        #1;
        check_eq("bp_accepted", 32'(n_acc - base), 32'(DEP));
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain("bp", 60);
    check_eq("bp_total", 32'(n_acc - base), 32'd6);

    // Wrap: 3*DEPTH random operands, random consumer
    base = n_out;
    for (int i = 0; i < 3 * DEP; i++)
      stim_q.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)});
    done = 1'b0;
    fork
      begin
        drive_all(400);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge iCLK); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    drain("wrap", 60);
    check_eq("wrap_count", 32'(n_out - base), 32'(3 * DEP));

    // Mid-flight reset: 1 buffered, 2 in flight
    out_ready = 1'b0;
    stim_q.push_back(32'h40A00000);
    drive_all(20);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge iCLK); #1;
    end
    stim_q.push_back(32'h40C00000);
    stim_q.push_back(32'h40E00000);
    drive_all(20);
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    check_eq("mid_out_valid_pre", 32'(out_valid), 32'd1);
    iRESET_N = 1'b0;
    #1;
    check_eq("mid_out_valid_rst", 32'(out_valid), 32'd0);
    check_eq("mid_busy_rst", 32'(busy), 32'd0);
    sb_q.delete();
    @(posedge iCLK);
    @(posedge iCLK); #1;
    iRESET_N = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    ovs = 0;
    repeat (15) begin
      @(negedge iCLK);
      if (out_valid) ovs++;
    end
    check_eq("mid_no_stale_valid", 32'(ovs), 32'd0);
    check_eq("mid_no_stale_out", 32'(n_out - base), 32'd0);
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
